// File: rtl/handshake_fifo_if.sv
// Handshake bundle between a DIR/ack producer, the FIFO, and a DOR/ack consumer.
// master = the producer/consumer side, slave = the FIFO side.
interface handshake_fifo_if #(
    parameter int WIDTH = 32
) ();
    logic             DIR;
    logic [WIDTH-1:0] data_in;
    logic             ack_from_fifo;
    logic             DOR;
    logic [WIDTH-1:0] data_out;
    logic             ack_to_fifo;

    modport master (
        output DIR,
        output data_in,
        output ack_to_fifo,
        input  ack_from_fifo,
        input  DOR,
        input  data_out
    );

    modport slave (
        input  DIR,
        input  data_in,
        input  ack_to_fifo,
        output ack_from_fifo,
        output DOR,
        output data_out
    );
endinterface

// File: rtl/handshake_fifo.sv
// Buffered DIR/ack -> DOR/ack bridge built around a small register FIFO.
// Optional macro HS_FIFO_LEVEL_EN exposes the entry count on port level.
module handshake_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                clk,
    input  logic                reset,
    handshake_fifo_if.slave     bus
`ifdef HS_FIFO_LEVEL_EN
    ,
    output logic [DEPTH_LOG2:0] level
`endif
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_reg;
    logic [DEPTH_LOG2-1:0] wr_ptr_next;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg;
    logic [DEPTH_LOG2-1:0] rd_ptr_next;
    logic [DEPTH_LOG2:0]   count_reg;
    logic [DEPTH_LOG2:0]   count_next;
    logic                  ack_out_reg;
    logic                  ack_out_next;
    logic                  ack_in_q_reg;
    logic                  push;
    logic                  pop;
    logic                  dor;
    logic [DEPTH-1:0]      wr_en;

    // The cycle after our ack never pushes: the producer has not dropped DIR yet.
    assign push = bus.DIR && !ack_out_reg && (count_reg < FULL_COUNT);
    // Only the rising level of the consumer ack pops, and never while empty.
    assign pop  = bus.ack_to_fifo && !ack_in_q_reg && (count_reg != '0);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = push && (wr_ptr_reg == DEPTH_LOG2'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en[i]) begin
                mem[i] <= bus.data_in;
            end
        end
    end

    always_comb begin
        wr_ptr_next  = wr_ptr_reg;
        rd_ptr_next  = rd_ptr_reg;
        count_next   = count_reg;
        ack_out_next = push;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + DEPTH_LOG2'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + DEPTH_LOG2'(1);
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + (DEPTH_LOG2 + 1)'(1);
            2'b01:   count_next = count_reg - (DEPTH_LOG2 + 1)'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            ack_out_reg  <= 1'b0;
            ack_in_q_reg <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            ack_out_reg  <= ack_out_next;
            ack_in_q_reg <= bus.ack_to_fifo;
        end
    end

    assign dor               = (count_reg != '0);
    assign bus.DOR           = dor;
    assign bus.data_out      = dor ? mem[rd_ptr_reg] : '0;
    assign bus.ack_from_fifo = ack_out_reg;

`ifdef HS_FIFO_LEVEL_EN
    assign level = count_reg;
`endif
endmodule

// File: tb/tb_handshake_fifo.sv
// Directed bench for handshake_fifo with a word scoreboard and immediate-assert checks.
module tb_handshake_fifo;
    logic clk;
    logic reset;
`ifdef HS_FIFO_LEVEL_EN
    logic [2:0] level;
`endif

    handshake_fifo_if #(.WIDTH(32)) bus ();

    handshake_fifo #(.WIDTH(32), .DEPTH_LOG2(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef HS_FIFO_LEVEL_EN
        ,
        .level (level)
`endif
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_level(input logic [31:0] exp);
`ifdef HS_FIFO_LEVEL_EN
        check("level", {29'd0, level}, exp);
`else
        if (exp > 0) check("dor_for_level", {31'd0, bus.DOR}, 32'd1);
        else         check("dor_for_level", {31'd0, bus.DOR}, 32'd0);
`endif
    endtask

    // Offer a word, wait (bounded) for the ack, then drop DIR and confirm the ack is a pulse.
    task automatic produce(input logic [31:0] word, output int waited);
        logic seen;
        bus.DIR     = 1'b1;
        bus.data_in = word;
        sb.push_back(word);
        waited = 0;
        seen   = 1'b0;
        while (!seen && waited < 20) begin
            tick();
            waited++;
            seen = bus.ack_from_fifo;
        end
        check("ack_seen", {31'd0, seen}, 32'd1);
        bus.DIR = 1'b0;
        tick();
        check("ack_pulse", {31'd0, bus.ack_from_fifo}, 32'd0);
    endtask

    task automatic consume();
        logic [31:0] exp;
        check("dor_before_pop", {31'd0, bus.DOR}, 32'd1);
        if (sb.size() > 0) begin
            exp = sb.pop_front();
            check("pop_data", bus.data_out, exp);
        end
        bus.ack_to_fifo = 1'b1;
        tick();
        bus.ack_to_fifo = 1'b0;
        tick();
    endtask

    initial begin
        int w;
        logic [31:0] exp;
        logic seen;
        bus.DIR         = 1'b0;
        bus.data_in     = '0;
        bus.ack_to_fifo = 1'b0;
        reset           = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset then idle
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_dor", {31'd0, bus.DOR}, 32'd0);
            check("idle_data", bus.data_out, 32'd0);
            check("idle_ack", {31'd0, bus.ack_from_fifo}, 32'd0);
        end
        check_level(0);

        // Single word
        produce(32'h4, w);
        check("push_latency", w, 32'd1);
        check("single_dor", {31'd0, bus.DOR}, 32'd1);
        check("single_data", bus.data_out, 32'h4);
        exp = sb.pop_front();
        check("single_head", bus.data_out, exp);
        bus.ack_to_fifo = 1'b1;
        tick();
        bus.ack_to_fifo = 1'b0;
        check("single_empty_dor", {31'd0, bus.DOR}, 32'd0);
        check("single_empty_data", bus.data_out, 32'd0);
        tick();

        // Fill with consumer stalled
        for (int i = 0; i < 4; i++) produce(32'(i * 4), w);
        check_level(4);
        bus.DIR     = 1'b1;
        bus.data_in = 32'd16;
        sb.push_back(32'd16);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("full_no_ack", {31'd0, bus.ack_from_fifo}, 32'd0);
        end
        exp = sb.pop_front();
        check("full_head", bus.data_out, exp);
        bus.ack_to_fifo = 1'b1;
        tick();
        bus.ack_to_fifo = 1'b0;
        check("full_pop_edge_no_push", {31'd0, bus.ack_from_fifo}, 32'd0);
        tick();
        check("full_late_ack", {31'd0, bus.ack_from_fifo}, 32'd1);
        bus.DIR = 1'b0;
        tick();
        check_level(4);
        for (int i = 0; i < 4; i++) consume();
        check("drain_dor", {31'd0, bus.DOR}, 32'd0);

        // Held ack pops exactly one word
        produce(32'd0, w);
        produce(32'd4, w);
        exp = sb.pop_front();
        check("held_head", bus.data_out, exp);
        bus.ack_to_fifo = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("held_dor", {31'd0, bus.DOR}, 32'd1);
        check("held_data", bus.data_out, 32'd4);
        bus.ack_to_fifo = 1'b0;
        tick();
        consume();
        check("held_empty", {31'd0, bus.DOR}, 32'd0);

        // Ack while empty is ignored
        bus.ack_to_fifo = 1'b1;
        tick();
        bus.ack_to_fifo = 1'b0;
        tick();
        check("underflow_dor", {31'd0, bus.DOR}, 32'd0);
        produce(32'h55, w);
        check_level(1);
        consume();
        check("underflow_after", {31'd0, bus.DOR}, 32'd0);

        // Simultaneous push/pop at level 2 across pointer wrap
        produce(32'd0, w);
        produce(32'd4, w);
        for (int v = 8; v <= 36; v += 4) begin
            exp = sb.pop_front();
            check("sim_head", bus.data_out, exp);
            sb.push_back(32'(v));
            bus.DIR         = 1'b1;
            bus.data_in     = 32'(v);
            bus.ack_to_fifo = 1'b1;
            tick();
            check("sim_ack", {31'd0, bus.ack_from_fifo}, 32'd1);
            bus.DIR         = 1'b0;
            bus.ack_to_fifo = 1'b0;
            tick();
            check_level(2);
        end
        consume();
        consume();
        check("sim_drain", {31'd0, bus.DOR}, 32'd0);

        // Reset mid-operation at level 3 with ack high
        produce(32'd200, w);
        produce(32'd204, w);
        bus.DIR     = 1'b1;
        bus.data_in = 32'd208;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = bus.ack_from_fifo;
        end
        check("rst_pre_ack", {31'd0, seen}, 32'd1);
        check_level(3);
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        bus.DIR = 1'b0;
        check("rst_dor", {31'd0, bus.DOR}, 32'd0);
        check("rst_ack", {31'd0, bus.ack_from_fifo}, 32'd0);
        check("rst_data", bus.data_out, 32'd0);
        check_level(0);
        sb.delete();
        tick();
        produce(32'd100, w);
        check("rst_first_word", bus.data_out, 32'd100);
        consume();
        check("rst_final_empty", {31'd0, bus.DOR}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/handshake_fifo.md
# handshake_fifo

Buffered DIR/ack-to-DOR/ack bridge: accepts words from a DIR/ack producer, such as the instruction-address sequencer, and stores them in a small FIFO. It presents the buffered words to a DOR/ack consumer, such as the pipeline's fetch stage. It is the receiving end of the producer-side handshake and the transmitting end of the consumer-side handshake. This lets a producer that runs ahead of the pipeline keep issuing without waiting on each downstream ack.

## Interface
- WIDTH, 32, data word width in bits
- DEPTH_LOG2, 2, log2 of FIFO depth (DEPTH = 2**DEPTH_LOG2, default 4 entries)

- clk  input  1  clock; all logic on posedge
- reset  input  1  synchronous, active-high reset
- DIR  input  1  producer data-in-ready; data_in valid while high
- data_in  input  WIDTH  producer word
- ack_from_fifo  output  1  one-cycle ack to producer; word captured
- DOR  output  1  data-out-ready; FIFO non-empty, data_out valid
- data_out  output  WIDTH  head-of-FIFO word; 0 when empty
- ack_to_fifo  input  1  consumer ack; a rising level pops the head
- level  output  DEPTH_LOG2+1  entry count (only with HS_FIFO_LEVEL_EN)

## Operation
- Storage: DEPTH x WIDTH register array with DEPTH_LOG2-bit wr_ptr/rd_ptr and a DEPTH_LOG2+1-bit count. Pointers wrap modulo DEPTH with no special case.
- Push rule, evaluated on register values before the edge:
  - Push when DIR=1, ack_from_fifo=0 and count<DEPTH.
  - On push: mem[wr_ptr]<=data_in, wr_ptr++, ack_from_fifo<=1.
  - Otherwise ack_from_fifo<=0.
- Ack is a one-cycle pulse. The cycle after an ack never pushes, even if DIR is still high, because the producer has not yet seen the ack and dropped DIR.
- Full (count==DEPTH): no ack. The producer holds DIR/data_in until space frees.
- Pop rule:
  - ack_q is a registered copy of ack_to_fifo.
  - Pop when ack_to_fifo=1, ack_q=0 and count!=0.
  - On pop: rd_ptr++.
  - An ack held high for several cycles pops exactly one word.
  - An ack while empty is ignored: no underflow, count stays 0.
- Simultaneous push and pop on the same edge: count unchanged, both pointers advance.
- Push permission uses pre-edge count. If full, no push occurs even when a pop happens on the same edge.
- DOR = (count!=0) and data_out = DOR ? mem[rd_ptr] : 0. Both depend on registers only; there is no combinational path from any input.
- Reset (also mid-transfer): count=0, wr_ptr=0, rd_ptr=0, ack_from_fifo=0, ack_q=0, hence DOR=0 and data_out=0. Buffered words are discarded. The array is not cleared.

## Timing
- Push latency into an empty FIFO: word captured at edge k; DOR=1 and data_out=word in the cycle after edge k.
- Pop: with ack_to_fifo rising in the cycle before edge m, the next word (or DOR=0 if none) appears after edge m.
- Minimum producer spacing is 2 cycles (ack cycle plus blocked cycle). The standard producer that waits for ack low achieves one word per 3 cycles.
- With a consumer that pulses ack one cycle per word, DOR stays high across back-to-back words and the consumer sees the new data_out on its next sampling edge.
- Max occupancy is DEPTH. count never exceeds DEPTH and never wraps below 0.

## Configuration
- HS_FIFO_LEVEL_EN:
  - Defined: port level exists and equals count (0..DEPTH), 0 after reset.
  - Undefined: port level is absent and count remains internal.
  - FIFO behaviour is identical either way.

## Test plan
- Reset then idle: DIR=0, ack_to_fifo=0 for 10 cycles -> DOR=0, data_out=0, ack_from_fifo=0 every cycle.
- Single word: DIR=1, data_in=32'h00000004 until ack -> ack_from_fifo high exactly one cycle, then DOR=1, data_out=4 the next cycle. One consumer ack pulse -> DOR=0 on the cycle after.
- Fill with consumer stalled: producer pushes 0,4,8,12,16 -> four acks, level=4, fifth DIR held with no ack. One consumer ack -> 16 accepted within 2 cycles, then outputs appear in order 4,8,12,16.
- Held ack: consumer holds ack_to_fifo high 5 cycles with words 0,4 buffered -> only 0 popped, DOR=1, data_out=4.
- Simultaneous push/pop at level=2 -> level stays 2, order preserved across pointer wrap after 10 words (0..36 in sequence).
- Reset mid-operation at level=3 with ack_from_fifo=1 -> next cycle DOR=0, ack_from_fifo=0, level=0. The next pushed word 100 is output first.
